// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, reset-cause
// codes and a counter-width helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_BTN = 2'd1;
    localparam logic [1:0] CAUSE_WDT = 2'd2;

    // Bits needed for a counter running 0 .. n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        if (n < 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rst_seq_btn_debounce.sv
// Push-button conditioning: two-flop synchronizer followed by a debounce
// counter; provides the debounced pressed level and a one-cycle press strobe.
module btn_debounce
    import rst_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 60000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic press
);

    localparam int              DW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]   DEB_LAST = DW'(DEBOUNCE_CYCLES - 32'sd1);

    logic [1:0]    sync_r;
    logic [DW-1:0] cnt_r;
    logic          pressed_r;
    logic          press_r;
    logic          sample_pressed_s;

    // Synchronized sample expressed as a pressed level (button is active-low)
    always_comb begin
        sample_pressed_s = ~sync_r[1];
    end

    // Two-flop synchronizer; idles high so a released button reads as not pressed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], btn_n};
        end
    end

    // Debounce: the level only follows a sample that stays different long enough
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {DW{1'b0}};
            pressed_r <= 1'b0;
            press_r   <= 1'b0;
        end else begin
            press_r <= 1'b0;
            if (sample_pressed_s == pressed_r) begin
                cnt_r <= {DW{1'b0}};
            end else if (cnt_r == DEB_LAST) begin
                cnt_r     <= {DW{1'b0}};
                pressed_r <= sample_pressed_s;
                press_r   <= sample_pressed_s;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    assign pressed = pressed_r;
    assign press   = press_r;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds all domain resets, stretches, then releases them in
// order; re-enters the sequence on a debounced button press or watchdog expiry.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int STAGES          = 3,
    parameter int STRETCH_CYCLES  = 16,
    parameter int STAGE_GAP       = 8,
    parameter int DEBOUNCE_CYCLES = 60000,
    parameter int WDT_CYCLES      = 6000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_n,
    input  logic              wdt_kick,
    output logic [STAGES-1:0] rst_stage,
    output logic              ready,
    output logic [1:0]        cause
);

    localparam int                SW           = cnt_width((STRETCH_CYCLES > STAGE_GAP) ?
                                                           STRETCH_CYCLES : STAGE_GAP);
    localparam logic [SW-1:0]     STRETCH_LAST = SW'(STRETCH_CYCLES - 32'sd1);
    localparam logic [SW-1:0]     GAP_LAST     = SW'(STAGE_GAP - 32'sd1);
    localparam bit                WDT_EN       = (WDT_CYCLES > 32'sd0);
    localparam int                WW           = cnt_width(WDT_CYCLES);
    localparam logic [WW-1:0]     WDT_LAST     = WW'(WDT_EN ? (WDT_CYCLES - 32'sd1) : 32'sd0);
    localparam logic [STAGES-1:0] ALL_ON       = {STAGES{1'b1}};
    // Only the highest stage still asserted: the next release finishes the sequence
    localparam logic [STAGES-1:0] LAST_MASK    = STAGES'(1'b1) << (STAGES - 32'sd1);

    state_e            state_r;
    logic [SW-1:0]     seq_cnt_r;
    logic [STAGES-1:0] rst_stage_r;
    logic              ready_r;
    logic [1:0]        cause_r;
    logic              wdt_armed_r;
    logic [WW-1:0]     wdt_cnt_r;

    logic              btn_pressed_s;
    logic              btn_press_s;
    logic              wdt_expire_s;
    logic              trig_s;
    logic [1:0]        trig_cause_s;
    logic [SW-1:0]     seq_last_s;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_n   (btn_n),
        .pressed (btn_pressed_s),
        .press   (btn_press_s)
    );

    // Soft-reset triggers; a button press outranks a coincident watchdog expiry
    always_comb begin
        wdt_expire_s = WDT_EN && wdt_armed_r && (wdt_cnt_r == {WW{1'b0}}) && !wdt_kick;
        trig_s       = 1'b0;
        trig_cause_s = CAUSE_POR;
        if ((state_r != HOLD) && btn_press_s) begin
            trig_s       = 1'b1;
            trig_cause_s = CAUSE_BTN;
        end else if ((state_r == RUN) && wdt_expire_s) begin
            trig_s       = 1'b1;
            trig_cause_s = CAUSE_WDT;
        end else begin
            trig_s       = 1'b0;
            trig_cause_s = CAUSE_POR;
        end
    end

    // Terminal count of the current timing phase
    always_comb begin
        if (state_r == STRETCH) begin
            seq_last_s = STRETCH_LAST;
        end else begin
            seq_last_s = GAP_LAST;
        end
    end

    // Sequencer FSM with registered outputs and the watchdog counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= HOLD;
            seq_cnt_r   <= {SW{1'b0}};
            rst_stage_r <= ALL_ON;
            ready_r     <= 1'b0;
            cause_r     <= CAUSE_POR;
            wdt_armed_r <= 1'b0;
            wdt_cnt_r   <= {WW{1'b0}};
        end else if (trig_s) begin
            state_r     <= HOLD;
            seq_cnt_r   <= {SW{1'b0}};
            rst_stage_r <= ALL_ON;
            ready_r     <= 1'b0;
            cause_r     <= trig_cause_s;
            wdt_armed_r <= 1'b0;
            wdt_cnt_r   <= {WW{1'b0}};
        end else begin
            case (state_r)
                HOLD: begin
                    seq_cnt_r <= {SW{1'b0}};
                    if (!btn_pressed_s) begin
                        state_r <= STRETCH;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                STRETCH, RELEASE: begin
                    if (seq_cnt_r == seq_last_s) begin
                        seq_cnt_r   <= {SW{1'b0}};
                        rst_stage_r <= rst_stage_r << 1'b1;
                        if (rst_stage_r == LAST_MASK) begin
                            state_r <= RUN;
                            ready_r <= 1'b1;
                        end else begin
                            state_r <= RELEASE;
                        end
                    end else begin
                        seq_cnt_r <= seq_cnt_r + 1'b1;
                    end
                end
                RUN: begin
                    if (WDT_EN && wdt_kick) begin
                        wdt_armed_r <= 1'b1;
                        wdt_cnt_r   <= WDT_LAST;
                    end else if (wdt_armed_r) begin
                        // Zero with no kick is handled as a trigger above
                        wdt_cnt_r <= wdt_cnt_r - 1'b1;
                    end else begin
                        wdt_cnt_r <= wdt_cnt_r;
                    end
                end
                default: begin
                    state_r     <= HOLD;
                    seq_cnt_r   <= {SW{1'b0}};
                    rst_stage_r <= ALL_ON;
                    ready_r     <= 1'b0;
                    wdt_armed_r <= 1'b0;
                    wdt_cnt_r   <= {WW{1'b0}};
                end
            endcase
        end
    end

    assign rst_stage = rst_stage_r;
    assign ready     = ready_r;
    assign cause     = cause_r;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: directed scenarios plus random button and
// kick traffic, compared cycle by cycle against a timeline-based reference model.
module tb_rst_seq;

    localparam int STAGES  = 3;
    localparam int STRETCH = 16;
    localparam int GAP     = 8;
    localparam int DEB     = 4;
    localparam int WDT     = 100;
    localparam int READY_T = STRETCH + (STAGES - 1) * GAP;

    logic              clk = 1'b0;
    logic              rst;
    logic              btn_n;
    logic              wdt_kick;
    logic [STAGES-1:0] rst_stage;
    logic              ready;
    logic [1:0]        cause;

    rst_seq #(
        .STAGES          (STAGES),
        .STRETCH_CYCLES  (STRETCH),
        .STAGE_GAP       (GAP),
        .DEBOUNCE_CYCLES (DEB),
        .WDT_CYCLES      (WDT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .wdt_kick  (wdt_kick),
        .rst_stage (rst_stage),
        .ready     (ready),
        .cause     (cause)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: outputs follow from the time elapsed since the sequence
    // started; the button level follows the last DEB samples; the watchdog
    // fires WDT edges after the last kick seen while running.
    bit m_hold;
    int m_t;
    int m_cause;
    bit m_armed;
    int m_last;
    int m_n;
    bit m_pressed;
    bit m_pend;
    bit raw_q[$];
    bit win_q[$];

    function automatic logic [STAGES-1:0] exp_stage();
        logic [STAGES-1:0] v;
        for (int k = 0; k < STAGES; k++) begin
            v[k] = m_hold || (m_t < STRETCH + k * GAP);
        end
        return v;
    endfunction

    function automatic bit exp_ready();
        return !m_hold && (m_t >= READY_T);
    endfunction

    task automatic model_reset();
        m_hold    = 1'b1;
        m_t       = 0;
        m_cause   = 0;
        m_armed   = 1'b0;
        m_last    = 0;
        m_pressed = 1'b0;
        m_pend    = 1'b0;
        raw_q     = {1'b1, 1'b1};
        win_q     = {};
    endtask

    task automatic model_edge(input bit btn, input bit kick);
        bit pre_hold, pre_ready, pre_pressed, pre_pend, samp, all_diff;
        pre_hold    = m_hold;
        pre_ready   = exp_ready();
        pre_pressed = m_pressed;
        pre_pend    = m_pend;
        if (pre_hold) begin
            if (!pre_pressed) begin
                m_hold = 1'b0;
                m_t    = 0;
            end
        end else if (pre_pend) begin
            m_hold  = 1'b1;
            m_cause = 1;
            m_armed = 1'b0;
        end else if (pre_ready && !kick && m_armed && (m_n - m_last >= WDT)) begin
            m_hold  = 1'b1;
            m_cause = 2;
            m_armed = 1'b0;
        end else begin
            if (pre_ready && kick) begin
                m_armed = 1'b1;
                m_last  = m_n;
            end
            if (m_t < READY_T) m_t++;
        end
        // button: two-sample delay, then level flips after DEB differing samples
        raw_q.push_back(btn);
        samp = raw_q.pop_front();
        win_q.push_back(!samp);
        if (win_q.size() > DEB) void'(win_q.pop_front());
        m_pend = 1'b0;
        if (win_q.size() == DEB) begin
            all_diff = 1'b1;
            foreach (win_q[i]) if (win_q[i] == m_pressed) all_diff = 1'b0;
            if (all_diff) begin
                m_pressed = !m_pressed;
                m_pend    = m_pressed;
                win_q     = {};
            end
        end
        m_n++;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_stage"}, rst_stage, exp_stage());
        check({tag, "_ready"}, ready, exp_ready());
        check({tag, "_cause"}, cause, m_cause);
    endtask

    // One clock: drive at the falling edge, model the rising edge, sample at the next fall
    task automatic step(input bit btn, input bit kick);
        btn_n    = btn;
        wdt_kick = kick;
        @(posedge clk);
        model_edge(btn, kick);
        @(negedge clk);
        check_outputs("cyc");
    endtask

    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1;
        check("async_rst_stage", rst_stage, 3'b111);
        check("async_rst_ready", ready, 1'b0);
        check("async_rst_cause", cause, 2'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int btn_low_left;
        rst      = 1'b1;
        btn_n    = 1'b1;
        wdt_kick = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("por_stage", rst_stage, 3'b111);
        check("por_ready", ready, 1'b0);
        check("por_cause", cause, 2'd0);
        rst = 1'b0;

        // POR release timing (step e is edge e)
        for (int e = 0; e <= 40; e++) begin
            step(1'b1, 1'b0);
            if (e == 15) check("edge15_stage", rst_stage, 3'b111);
            if (e == 16) check("edge16_stage", rst_stage, 3'b110);
            if (e == 23) check("edge23_stage", rst_stage, 3'b110);
            if (e == 24) check("edge24_stage", rst_stage, 3'b100);
            if (e == 31) check("edge31_ready", ready, 1'b0);
            if (e == 32) check("edge32_stage", rst_stage, 3'b000);
            if (e == 32) check("edge32_ready", ready, 1'b1);
        end

        // short glitch is filtered
        repeat (3) step(1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0);
        check("glitch_ready", ready, 1'b1);

        // long press: hold, then replay the sequence
        repeat (20) step(1'b0, 1'b0);
        check("press_stage", rst_stage, 3'b111);
        check("press_cause", cause, 2'd1);
        repeat (60) step(1'b1, 1'b0);
        check("press_replay_ready", ready, 1'b1);

        // watchdog: single kick then silence
        step(1'b1, 1'b1);
        repeat (99) step(1'b1, 1'b0);
        check("wdt_pre_ready", ready, 1'b1);
        step(1'b1, 1'b0);
        check("wdt_exp_stage", rst_stage, 3'b111);
        check("wdt_exp_cause", cause, 2'd2);
        repeat (40) step(1'b1, 1'b0);

        // regular kicks keep it alive
        for (int i = 0; i < 1000; i++) step(1'b1, (i % 50) == 0);
        check("wdt_kept_ready", ready, 1'b1);

        // kick exactly on the zero-count cycle
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 1; i < 100; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("collide_kick_ready", ready, 1'b1);

        // button press strobe lands on the expiry edge
        for (int j = 1; j <= 110; j++) begin
            step(!(j >= 94 && j <= 103), 1'b0);
            if (j == 100) check("collide_btn_cause", cause, 2'd1);
        end
        repeat (60) step(1'b1, 1'b0);

        // press during RELEASE after stage 0 has fallen
        pulse_rst();
        repeat (20) step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        check("release_press_stage", rst_stage, 3'b111);
        check("release_press_cause", cause, 2'd1);
        repeat (60) step(1'b1, 1'b0);

        // asynchronous rst while running
        pulse_rst();
        repeat (40) step(1'b1, 1'b0);

        // random traffic
        btn_low_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (btn_low_left == 0 && $urandom_range(59, 0) == 0)
                btn_low_left = $urandom_range(12, 1);
            if ($urandom_range(1499, 0) == 0) pulse_rst();
            step(btn_low_left == 0, $urandom_range(44, 0) == 0);
            if (btn_low_left > 0) btn_low_left--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
